// File: rtl/mdu_iter_if.sv
// Request/response bundle between the EXU, the iterative multiply/divide unit and writeback.
// The master is the EXU/writeback side; the slave is the unit itself.
interface mdu_iter_if #(
  parameter int XLEN = 32
) ();
  // A transfer happens on a rising clk edge where valid && ready; the producer holds its
  // payload and valid stable until that edge, and ready may depend on state but never on valid.
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      func3;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;

  modport master (
    output in_valid, func3, rs1, rs2, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, func3, rs1, rs2, out_ready,
    output in_ready, out_valid, result
  );
endinterface

// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, one bit per cycle.
// Define MDU_FAST_MUL_EN to compute multiplies with a single-cycle combinational multiplier.
module mdu_iter #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  mdu_iter_if.slave  bus,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          op_q;
  logic                neg_q;
  logic [XLEN-1:0]     opb_q;
  logic [2*XLEN-1:0]   acc_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [XLEN-1:0]     result_q;

  logic                is_div_in, sgn_a_in, sgn_b_in, neg_a, neg_b, neg_in;
  logic [XLEN-1:0]     mag_a, mag_b;
  logic                div_zero, div_ovf, special, fast_done, accept, last_iter;
  logic [XLEN-1:0]     special_res;
  logic                src_div;
  logic [2*XLEN-1:0]   src_acc, iter_next;
  logic [XLEN-1:0]     src_opb;
  logic [XLEN:0]       mul_sum, trial;

  // Sign-correct a magnitude result and select the architecturally visible half.
  function automatic logic [XLEN-1:0] finish_op(input logic [2:0] op, input logic neg,
                                                 input logic [2*XLEN-1:0] v);
    logic [2*XLEN-1:0] p;
    logic [XLEN-1:0]   q, r, res;
    p = neg ? -v : v;
    q = neg ? -v[XLEN-1:0] : v[XLEN-1:0];
    r = neg ? -v[2*XLEN-1:XLEN] : v[2*XLEN-1:XLEN];
    case (op)
      3'b000:                 res = p[XLEN-1:0];
      3'b001, 3'b010, 3'b011: res = p[2*XLEN-1:XLEN];
      3'b100, 3'b101:         res = q;
      default:                res = r;
    endcase
    return res;
  endfunction

  assign is_div_in = bus.func3[2];
  assign sgn_a_in  = is_div_in ? ~bus.func3[0] : (bus.func3 == 3'b001 || bus.func3 == 3'b010);
  assign sgn_b_in  = is_div_in ? ~bus.func3[0] : (bus.func3 == 3'b001);
  assign neg_a     = sgn_a_in & bus.rs1[XLEN-1];
  assign neg_b     = sgn_b_in & bus.rs2[XLEN-1];
  assign mag_a     = neg_a ? -bus.rs1 : bus.rs1;
  assign mag_b     = neg_b ? -bus.rs2 : bus.rs2;
  // Remainders follow the dividend; products and quotients follow the sign difference.
  assign neg_in    = (is_div_in && bus.func3[1]) ? neg_a : (neg_a ^ neg_b);

  assign div_zero  = is_div_in && (bus.rs2 == '0);
  assign div_ovf   = is_div_in && !bus.func3[0] && (bus.rs2 == '1) &&
                     (bus.rs1 == {1'b1, {(XLEN-1){1'b0}}});
  assign special   = div_zero || div_ovf;
  assign special_res = div_zero ? (bus.func3[1] ? bus.rs1 : '1)
                                : (bus.func3[1] ? '0 : bus.rs1);

`ifdef MDU_FAST_MUL_EN
  logic [2*XLEN-1:0] prod_fast;
  assign prod_fast = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
  assign fast_done = !is_div_in;
`else
  assign fast_done = 1'b0;
`endif

  assign accept    = bus.in_valid && (state_q == IDLE) && !flush;
  assign last_iter = (cnt_q == CNT_W'(XLEN - 2));

  // The first iteration runs on the accepting edge straight from the operand magnitudes,
  // so CALC needs only XLEN-1 further cycles.
  assign src_div = (state_q == IDLE) ? is_div_in : op_q[2];
  assign src_acc = (state_q == IDLE) ? {{XLEN{1'b0}}, (is_div_in ? mag_a : mag_b)} : acc_q;
  assign src_opb = (state_q == IDLE) ? (is_div_in ? mag_b : mag_a) : opb_q;

  assign mul_sum = {1'b0, src_acc[2*XLEN-1:XLEN]} + {1'b0, (src_acc[0] ? src_opb : '0)};
  assign trial   = {src_acc[2*XLEN-1:XLEN], src_acc[XLEN-1]} - {1'b0, src_opb};

  always_comb begin
    iter_next = {mul_sum, src_acc[XLEN-1:1]};
    if (src_div) begin
      if (trial[XLEN]) iter_next = {src_acc[2*XLEN-2:XLEN-1], src_acc[XLEN-2:0], 1'b0};
      else             iter_next = {trial[XLEN-1:0], src_acc[XLEN-2:0], 1'b1};
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = (special || fast_done) ? DONE : CALC;
      CALC:    if (last_iter) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= '0;
      neg_q    <= 1'b0;
      opb_q    <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else if (flush) begin
      cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          op_q  <= bus.func3;
          neg_q <= neg_in;
          opb_q <= src_opb;
          acc_q <= iter_next;
          cnt_q <= '0;
          if (special) result_q <= special_res;
`ifdef MDU_FAST_MUL_EN
          else if (fast_done) result_q <= finish_op(bus.func3, neg_in, prod_fast);
`endif
        end
        CALC: begin
          acc_q <= iter_next;
          cnt_q <= cnt_q + 1'b1;
          if (last_iter) result_q <= finish_op(op_q, neg_q, iter_next);
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = result_q;
  assign dbg_state     = state_q;

endmodule
